// File: rtl/calab3_pkg.sv
// calab3_pkg: shared sizes and write-side FSM state for the calab3 operand bank
package calab3_pkg;
  localparam int CALAB3_ADDR_W = 5;
  localparam int CALAB3_NREGS = 32;
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} calab3_wr_state_t;
endpackage

// File: rtl/calab3_dec5to32.sv
// calab3_dec5to32: 5-bit to 32-bit one-hot decoder with enable
module calab3_dec5to32
  import calab3_pkg::*;
(
  input  logic [CALAB3_ADDR_W-1:0] i_addr,
  input  logic                     i_en,
  output logic [CALAB3_NREGS-1:0]  o_sel
);
  assign o_sel = i_en ? (CALAB3_NREGS'(1) << i_addr) : '0;
endmodule

// File: rtl/calab3_regbank_writer.sv
// calab3_regbank_writer: 32 x N operand bank write side with handshake writes and sequenced bulk clear
// Optional macro CALAB3_REG0_ZERO_EN ties q0 to zero and discards writes to address 0.
module calab3_regbank_writer
  import calab3_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [CALAB3_ADDR_W-1:0] wr_addr,
  input  logic [N-1:0]             wr_data,
  input  logic                     clr_req,
  output logic                     busy,
  output logic [N-1:0] q0,  q1,  q2,  q3,  q4,  q5,  q6,  q7,
  output logic [N-1:0] q8,  q9,  q10, q11, q12, q13, q14, q15,
  output logic [N-1:0] q16, q17, q18, q19, q20, q21, q22, q23,
  output logic [N-1:0] q24, q25, q26, q27, q28, q29, q30, q31
);
`ifdef CALAB3_REG0_ZERO_EN
  localparam bit REG0_ZERO = 1'b1;
`else
  localparam bit REG0_ZERO = 1'b0;
`endif
  calab3_wr_state_t          r_state;
  logic [CALAB3_ADDR_W-1:0]  r_clr_idx;
  logic [N-1:0]              r_q [CALAB3_NREGS];
  logic                      w_fire;
  logic [CALAB3_ADDR_W-1:0]  w_dec_addr;
  logic [CALAB3_NREGS-1:0]   w_sel;
  logic [N-1:0]              w_data;
  assign busy       = (r_state == CLEAR);
  assign wr_ready   = (r_state == IDLE) && !clr_req;
  assign w_fire     = wr_valid && wr_ready;
  // one decoder serves both the write port and the clear sweep
  assign w_dec_addr = busy ? r_clr_idx : wr_addr;
  assign w_data     = busy ? '0 : wr_data;
  calab3_dec5to32 u_dec (
    .i_addr (w_dec_addr),
    .i_en   (w_fire || busy),
    .o_sel  (w_sel)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_clr_idx <= '0;
    end else if (r_state == IDLE) begin
      r_clr_idx <= '0;
      if (clr_req) r_state <= CLEAR;
    end else begin
      r_clr_idx <= r_clr_idx + 1'b1;
      if (r_clr_idx == CALAB3_ADDR_W'(CALAB3_NREGS - 1)) r_state <= IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CALAB3_NREGS; i++) r_q[i] <= '0;
    end else begin
      for (int i = 0; i < CALAB3_NREGS; i++)
        if (w_sel[i] && !(REG0_ZERO && i == 0)) r_q[i] <= w_data;
    end
  end
  assign q0  = r_q[0];  assign q1  = r_q[1];  assign q2  = r_q[2];  assign q3  = r_q[3];
  assign q4  = r_q[4];  assign q5  = r_q[5];  assign q6  = r_q[6];  assign q7  = r_q[7];
  assign q8  = r_q[8];  assign q9  = r_q[9];  assign q10 = r_q[10]; assign q11 = r_q[11];
  assign q12 = r_q[12]; assign q13 = r_q[13]; assign q14 = r_q[14]; assign q15 = r_q[15];
  assign q16 = r_q[16]; assign q17 = r_q[17]; assign q18 = r_q[18]; assign q19 = r_q[19];
  assign q20 = r_q[20]; assign q21 = r_q[21]; assign q22 = r_q[22]; assign q23 = r_q[23];
  assign q24 = r_q[24]; assign q25 = r_q[25]; assign q26 = r_q[26]; assign q27 = r_q[27];
  assign q28 = r_q[28]; assign q29 = r_q[29]; assign q30 = r_q[30]; assign q31 = r_q[31];
endmodule

// File: tb/tb_calab3_regbank_writer.sv
// tb_calab3_regbank_writer: directed vectors, per-cycle model compare plus literal pins
module tb_calab3_regbank_writer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       clr_req = 1'b0;
  logic       busy;
  logic [7:0] q [32];
  int         n_pass = 0;
  int         n_total = 0;

  always #5 clk = ~clk;

  calab3_regbank_writer #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req), .busy(busy),
    .q0(q[0]),   .q1(q[1]),   .q2(q[2]),   .q3(q[3]),   .q4(q[4]),   .q5(q[5]),   .q6(q[6]),   .q7(q[7]),
    .q8(q[8]),   .q9(q[9]),   .q10(q[10]), .q11(q[11]), .q12(q[12]), .q13(q[13]), .q14(q[14]), .q15(q[15]),
    .q16(q[16]), .q17(q[17]), .q18(q[18]), .q19(q[19]), .q20(q[20]), .q21(q[21]), .q22(q[22]), .q23(q[23]),
    .q24(q[24]), .q25(q[25]), .q26(q[26]), .q27(q[27]), .q28(q[28]), .q29(q[29]), .q30(q[30]), .q31(q[31])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // model: register contents plus the number of clear cycles still owed
  logic [7:0] m_q [32];
  int         m_clr_left = 0;
  int         m_clr_pos = 0;
`ifdef CALAB3_REG0_ZERO_EN
  localparam bit M_REG0_ZERO = 1'b1;
`else
  localparam bit M_REG0_ZERO = 1'b0;
`endif

  initial for (int i = 0; i < 32; i++) m_q[i] = '0;

  always @(negedge rst_n) begin
    for (int i = 0; i < 32; i++) m_q[i] = '0;
    m_clr_left = 0;
    m_clr_pos = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (m_clr_left > 0) begin
        m_q[m_clr_pos] = '0;
        m_clr_pos++;
        m_clr_left--;
      end else if (clr_req) begin
        m_clr_left = 32;
        m_clr_pos = 0;
      end else if (wr_valid && !(M_REG0_ZERO && wr_addr == 5'd0)) begin
        m_q[wr_addr] = wr_data;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", {31'd0, busy}, {31'd0, m_clr_left > 0});
    chk("wr_ready", {31'd0, wr_ready}, {31'd0, (m_clr_left == 0) && !clr_req});
    for (int i = 0; i < 32; i++) chk($sformatf("q%0d", i), {24'd0, q[i]}, {24'd0, m_q[i]});
  end

  // called at posedge+2; returns at posedge+2 after the accepting edge
  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    int t = 0;
    wr_valid = 1'b1;
    wr_addr = a;
    wr_data = d;
    while (!wr_ready && t < 100) begin
      @(posedge clk); #2;
      t++;
    end
    if (t >= 100) chk("wr_timeout", 32'd1, 32'd0);
    @(posedge clk); #2;
    wr_valid = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 100) begin
      step(1);
      t++;
    end
    if (t >= 100) chk("busy_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    logic [7:0] any;
    int n;
    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ready", {31'd0, wr_ready}, 32'd1);
    any = '0;
    for (int i = 0; i < 32; i++) any |= q[i];
    chk("reset_q_all", {24'd0, any}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    step(1);
    // back-to-back writes
    wr(5'd7, 8'hA5);
    chk("q7_after_wr", {24'd0, q[7]}, 32'hA5);
    wr(5'd31, 8'h3C);
    chk("q31_after_wr", {24'd0, q[31]}, 32'h3C);
    chk("q7_held", {24'd0, q[7]}, 32'hA5);
    chk("q8_untouched", {24'd0, q[8]}, 32'h00);
    // same address, consecutive edges: last write wins
    wr(5'd9, 8'h01);
    wr(5'd9, 8'h02);
    chk("q9_last_wins", {24'd0, q[9]}, 32'h02);
    // fill then clear
    for (int i = 0; i < 32; i++) wr(5'(i), 8'(8'h40 + i));
    chk("q31_filled", {24'd0, q[31]}, 32'h5F);
    clr_req = 1'b1;
    step(1);
    clr_req = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      if (n == 6) begin
        chk("q5_cleared_by_c6", {24'd0, q[5]}, 32'h00);
        chk("q6_still_set_c6", {24'd0, q[6]}, 32'h46);
      end
      n++;
      step(1);
    end
    chk("busy_cycles", n, 32);
    any = '0;
    for (int i = 0; i < 32; i++) any |= q[i];
    chk("all_clear", {24'd0, any}, 32'd0);
    chk("ready_after_clear", {31'd0, wr_ready}, 32'd1);
    // clr_req and wr_valid together: write refused
    clr_req = 1'b1;
    wr_valid = 1'b1;
    wr_addr = 5'd3;
    wr_data = 8'hFF;
    #1;
    chk("ready_low_with_clr", {31'd0, wr_ready}, 32'd0);
    @(posedge clk); #2;
    clr_req = 1'b0;
    wr_valid = 1'b0;
    chk("busy_after_req", {31'd0, busy}, 32'd1);
    wait_idle();
    chk("q3_not_written", {24'd0, q[3]}, 32'h00);
    // reset in the middle of a clear
    wr(5'd20, 8'h99);
    wr(5'd25, 8'h55);
    clr_req = 1'b1;
    step(1);
    clr_req = 1'b0;
    step(10);
    chk("q20_before_reset", {24'd0, q[20]}, 32'h99);
    rst_n = 1'b0;
    #1;
    any = '0;
    for (int i = 0; i < 32; i++) any |= q[i];
    chk("midclear_reset_q", {24'd0, any}, 32'd0);
    chk("midclear_reset_busy", {31'd0, busy}, 32'd0);
    step(1);
    rst_n = 1'b1;
    step(1);
    wr(5'd2, 8'h11);
    chk("q2_after_reset", {24'd0, q[2]}, 32'h11);
    // address 0 write
    wr(5'd0, 8'h77);
`ifdef CALAB3_REG0_ZERO_EN
    chk("q0_zero_tied", {24'd0, q[0]}, 32'h00);
`else
    chk("q0_written", {24'd0, q[0]}, 32'h77);
`endif
    step(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/calab3_regbank_writer.md
# calab3_regbank_writer

Write side of the 32-entry operand bank: accepts single-register writes over a valid/ready handshake and decodes the 5-bit address to one of 32 N-bit registers. Also provides a sequenced bulk-clear. Registered outputs q0..q31 drive the i0..i31 inputs of the 32:1 read mux, which selects with a 5-bit `s`.

## Interface
- `N`, default 8: register width in bits.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `wr_valid`  in  1: write request.
- `wr_ready`  out  1: write can be accepted this cycle.
- `wr_addr`  in  5: target register index, 0..31; same encoding as the read mux `s`.
- `wr_data`  in  N: write data.
- `clr_req`  in  1: request a bulk clear of all registers. Sampled only in IDLE.
- `busy`  out  1: bulk clear in progress.
- `q0`..`q31`  out  N each: register contents, one port per entry.

## Operation
- FSM has two states, IDLE and CLEAR. Reset state is IDLE.
- `wr_ready` = (state == IDLE) && !`clr_req`. This is combinational from state and `clr_req`.
- Write fires when `wr_valid` && `wr_ready` at a rising edge.
  - When it fires, q[`wr_addr`] <= `wr_data`.
  - All other registers hold their value.
- IDLE with `clr_req`=1: go to CLEAR and set `clr_idx` to 0. A `wr_valid` in the same cycle is not accepted.
- CLEAR, each cycle:
  - q[`clr_idx`] <= 0 and `clr_idx` increments.
  - When `clr_idx`=31: clear q31, go to IDLE, and `clr_idx` wraps to 0.
  - Total time in CLEAR is exactly 32 cycles.
- In CLEAR, `clr_req` and `wr_valid` are ignored. Requesters must hold `wr_valid` until `wr_ready`.
- `busy` = (state == CLEAR).
- Address decode is one-hot with 5 bits, so every value 0..31 is valid. There is no out-of-range case.
- The write data path has no width conversion. `wr_data` is stored as-is, N bits.

## Timing
- Reset (`rst_n` low, asynchronous): q0..q31 = 0, state IDLE, `clr_idx` = 0, `busy` = 0. `wr_ready` follows !`clr_req`.
- Write latency: the new value appears on q[`wr_addr`] one cycle after the accepting edge. Through the read mux it is visible combinationally in that same cycle.
- Back-to-back writes are accepted every cycle. Writes to the same address on consecutive edges: the last write wins.
- Clear: `busy` rises the cycle after `clr_req` is sampled and stays high for 32 cycles. q[k] reads 0 from cycle k+1 after entering CLEAR.
- Reset asserted mid-clear: all registers go to 0 immediately. FSM returns to IDLE; no resume.

## Configuration
- `CALAB3_REG0_ZERO_EN` defined:
  - q0 is tied to constant 0.
  - A write to address 0 still completes the handshake (`wr_ready` unaffected), but the data is discarded.
  - CLEAR still takes 32 cycles.
- Undefined: q0 is an ordinary writable register.

## Structure
- Shared package `calab3_pkg` holds:
  - `CALAB3_ADDR_W` = 5 and `CALAB3_NREGS` = 32;
  - the FSM state typedef `calab3_wr_state_t` {IDLE, CLEAR}.
- `N` stays a module parameter, matched to the read mux `N`.
- One sub-module, `calab3_dec5to32`: combinational 5-bit to 32-bit one-hot decoder with enable.
  - Instantiated once.
  - Fed from `wr_addr` when writing and from `clr_idx` when clearing.
  - The data mux selects `wr_data` or 0.

## Test plan
- Reset then idle: all q = 0x00, `wr_ready`=1, `busy`=0.
- Write 0xA5 to address 7, then 0x3C to address 31 on the next cycle: q7=0xA5 and q31=0x3C one cycle after each accept; all other q stay 0.
- Fill all 32 registers with value = 0x40+index, then assert `clr_req` for 1 cycle:
  - `busy` is high for exactly 32 cycles;
  - q5 is 0 by cycle 6 after entry;
  - after `busy` falls, all q = 0 and `wr_ready`=1.
- `clr_req` and `wr_valid` (addr 3, 0xFF) in the same IDLE cycle: `wr_ready`=0, the write is not accepted, and q3 ends at 0.
- Assert `rst_n`=0 at CLEAR cycle 10: all q = 0 immediately, `busy`=0. After release, a write of 0x11 to addr 2 succeeds.
- With `CALAB3_REG0_ZERO_EN`: write 0x77 to addr 0; the handshake completes and q0 stays 0x00. Without the macro, q0 = 0x77.
